imm_gen_stage: RTL and testbench

//  Registered, parametrised immediate-generation stage for the pipelined RISC-V core, placed between fetch and EX.

---
 rtl/imm_gen_if.sv | 30 +++
 rtl/imm_gen_stage.sv | 122 ++++++++++++
 tb/tb_imm_gen_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_if.sv
// Valid/ready stream interface for the immediate-generation stage.
// Carries both the upstream (in_*) and downstream (out_*) channels of the stage.
interface imm_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_type;
    logic [XLEN-1:0]  in_pc;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_target;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_type, in_pc, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_type, in_pc, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate decoder with PC-relative target and a 2-entry skid buffer.
// Outputs come straight from the head register, so out_ready never reaches in_ready combinationally.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    imm_gen_if.slave bus
);
    // state | meaning
    // EMPTY | no buffered entry, out_valid=0
    // ONE   | head holds the only entry
    // FULL  | head plus skid entry, in_ready=0
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  target;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    logic [1:0] state_q, state_d;
    entry_t     head_q, head_d, skid_q, skid_d, new_e;
    logic       in_ready_q, out_valid_q;
    logic       in_fire, out_fire;
    logic [XLEN-1:0] imm;
    logic       pc_rel, illegal;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    always_comb begin
        imm     = '0;
        pc_rel  = 1'b0;
        illegal = 1'b0;
        case (bus.in_type)
            3'd0: imm = '0;
            3'd1: imm = XLEN'($signed(bus.in_instr[31:20]));
            3'd2: imm = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
            3'd3: begin
                imm    = XLEN'($signed({bus.in_instr[31], bus.in_instr[7], bus.in_instr[30:25],
                                        bus.in_instr[11:8], 1'b0}));
                pc_rel = 1'b1;
            end
            3'd4: begin
                imm    = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
                pc_rel = 1'b1;
            end
            3'd5: begin
                imm    = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12], bus.in_instr[20],
                                        bus.in_instr[30:21], 1'b0}));
                pc_rel = 1'b1;
            end
            3'd6: imm = XLEN'(bus.in_instr[19:15]);
            default: illegal = 1'b1;
        endcase
        new_e.imm     = imm;
        new_e.target  = pc_rel ? bus.in_pc + imm : '0;
        new_e.tag     = bus.in_tag;
        new_e.illegal = illegal;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    head_d  = new_e;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_d = new_e;
                end else if (in_fire) begin
                    skid_d  = new_e;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = head_q.imm;
    assign bus.out_target  = head_q.target;
    assign bus.out_tag     = head_q.tag;
    assign bus.out_illegal = head_q.illegal;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: XLEN=32 and XLEN=64 instances driven with identical stimulus.
module tb_imm_gen_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_gen_if #(.XLEN(32), .TAG_W(8)) if32 ();
    imm_gen_if #(.XLEN(64), .TAG_W(8)) if64 ();

    imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32.slave));
    imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64.slave));

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] instr;
        logic [63:0] pc;
        logic [7:0]  tag;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] typ, input logic [31:0] instr,
                         input logic [63:0] pc, input logic [7:0] tag);
        if32.in_valid = v;  if64.in_valid = v;
        if32.in_type  = typ; if64.in_type = typ;
        if32.in_instr = instr; if64.in_instr = instr;
        if32.in_pc    = pc[31:0]; if64.in_pc = pc;
        if32.in_tag   = tag; if64.in_tag = tag;
    endtask

    task automatic set_ordy(input logic r);
        if32.out_ready = r;
        if64.out_ready = r;
    endtask

    task automatic chk_vec(input vec_t v, input int k);
        string s;
        s = $sformatf("vec%0d", k);
        chk({s, " valid32"},   64'(if32.out_valid),   64'd1);
        chk({s, " imm32"},     64'(if32.out_imm),     64'(v.imm[31:0]));
        chk({s, " target32"},  64'(if32.out_target),  64'(v.tgt[31:0]));
        chk({s, " tag32"},     64'(if32.out_tag),     64'(v.tag));
        chk({s, " illegal32"}, 64'(if32.out_illegal), 64'(v.ill));
        chk({s, " valid64"},   64'(if64.out_valid),   64'd1);
        chk({s, " imm64"},     if64.out_imm,          v.imm);
        chk({s, " target64"},  if64.out_target,       v.tgt);
        chk({s, " tag64"},     64'(if64.out_tag),     64'(v.tag));
        chk({s, " illegal64"}, 64'(if64.out_illegal), 64'(v.ill));
    endtask

    task automatic chk_hs(input string nm, input logic ov, input logic ir, input logic [7:0] tag, input logic chk_tag);
        chk({nm, " out_valid"}, 64'(if32.out_valid), 64'(ov));
        chk({nm, " in_ready"},  64'(if32.in_ready),  64'(ir));
        chk({nm, " out_valid64"}, 64'(if64.out_valid), 64'(ov));
        chk({nm, " in_ready64"},  64'(if64.in_ready),  64'(ir));
        if (chk_tag) begin
            chk({nm, " out_tag"},   64'(if32.out_tag), 64'(tag));
            chk({nm, " out_tag64"}, 64'(if64.out_tag), 64'(tag));
        end
    endtask

    initial begin
        //              type  instr         pc                     tag    imm                    target                 ill
        vecs[0]  = '{3'd1, 32'hFFF00093, 64'h100,              8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 1'b0};
        vecs[1]  = '{3'd3, 32'hFE000EE3, 64'h2000,             8'h12, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1FFC,              1'b0};
        vecs[2]  = '{3'd4, 32'h800002B7, 64'h1000,             8'h13, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_1000, 1'b0};
        vecs[3]  = '{3'd6, 32'h000F8073, 64'h40,               8'h14, 64'd31,                  64'h0,                 1'b0};
        vecs[4]  = '{3'd5, 32'h0080006F, 64'hFFFF_FFFC,        8'h15, 64'd8,                   64'h1_0000_0004,       1'b0};
        vecs[5]  = '{3'd7, 32'hFFFFFFFF, 64'h40,               8'h16, 64'h0,                   64'h0,                 1'b1};
        vecs[6]  = '{3'd2, 32'hFE112E23, 64'h80,               8'h17, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,                 1'b0};
        vecs[7]  = '{3'd0, 32'hFFFFFFFF, 64'h80,               8'h18, 64'h0,                   64'h0,                 1'b0};
        vecs[8]  = '{3'd1, 32'h7FF00093, 64'h80,               8'h19, 64'h7FF,                 64'h0,                 1'b0};
        vecs[9]  = '{3'd3, 32'h00000863, 64'h100,              8'h1A, 64'h10,                  64'h110,               1'b0};
        vecs[10] = '{3'd4, 32'h12345037, 64'h10,               8'h1B, 64'h1234_5000,           64'h1234_5010,         1'b0};

        drive(1'b0, 3'd0, 32'h0, 64'h0, 8'h0);
        set_ordy(1'b0);
        #12;
        chk("reset out_valid", 64'(if32.out_valid), 64'd0);
        chk("reset in_ready",  64'(if32.in_ready),  64'd1);
        chk("reset out_imm",   if64.out_imm,        64'd0);
        chk("reset out_target", if64.out_target,    64'd0);
        chk("reset out_tag",   64'(if64.out_tag),   64'd0);
        chk("reset out_illegal", 64'(if64.out_illegal), 64'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back decode with a ready sink: each vector is visible one edge after it is driven.
        set_ordy(1'b1);
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, vecs[k].typ, vecs[k].instr, vecs[k].pc, vecs[k].tag);
            step();
            chk_vec(vecs[k], k);
        end
        drive(1'b0, 3'd0, 32'h0, 64'h0, 8'h0);
        step();
        chk_hs("drain", 1'b0, 1'b1, 8'h0, 1'b0);

        // Back-pressure: three inputs against a stalled sink.
        set_ordy(1'b0);
        drive(1'b1, 3'd1, 32'h00100093, 64'h0, 8'hA1);
        step();
        chk_hs("bp accept1", 1'b1, 1'b1, 8'hA1, 1'b1);
        drive(1'b1, 3'd1, 32'h00200093, 64'h0, 8'hA2);
        step();
        chk_hs("bp full", 1'b1, 1'b0, 8'hA1, 1'b1);
        drive(1'b1, 3'd1, 32'h00300093, 64'h0, 8'hA3);
        step();
        chk_hs("bp stall", 1'b1, 1'b0, 8'hA1, 1'b1);
        chk("bp stall imm held", 64'(if32.out_imm), 64'd1);
        set_ordy(1'b1);
        step();
        chk_hs("bp drain1", 1'b1, 1'b1, 8'hA2, 1'b1);
        chk("bp drain1 imm", 64'(if32.out_imm), 64'd2);
        step();
        chk_hs("bp drain2", 1'b1, 1'b1, 8'hA3, 1'b1);
        chk("bp drain2 imm", 64'(if32.out_imm), 64'd3);
        drive(1'b0, 3'd0, 32'h0, 64'h0, 8'h0);
        step();
        chk_hs("bp empty", 1'b0, 1'b1, 8'h0, 1'b0);

        // Flush while FULL with the sink ready and a new input offered.
        set_ordy(1'b0);
        drive(1'b1, 3'd1, 32'h00100093, 64'h0, 8'hB1);
        step();
        drive(1'b1, 3'd1, 32'h00200093, 64'h0, 8'hB2);
        step();
        chk_hs("flush pre full", 1'b1, 1'b0, 8'hB1, 1'b1);
        flush = 1'b1;
        set_ordy(1'b1);
        drive(1'b1, 3'd1, 32'h00300093, 64'h0, 8'hB3);
        step();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 64'h0, 8'h0);
        chk_hs("flush next", 1'b0, 1'b1, 8'h0, 1'b0);
        step();
        chk_hs("flush stays empty", 1'b0, 1'b1, 8'h0, 1'b0);

        // Flush in ONE overriding simultaneous in_fire and out_fire.
        drive(1'b1, 3'd1, 32'h00100093, 64'h0, 8'hC1);
        step();
        drive(1'b1, 3'd1, 32'h00200093, 64'h0, 8'hC2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 64'h0, 8'h0);
        chk_hs("flush one", 1'b0, 1'b1, 8'h0, 1'b0);

        // Asynchronous reset while FULL: outputs clear without a clock edge.
        set_ordy(1'b0);
        drive(1'b1, 3'd5, 32'h0080006F, 64'h100, 8'hD1);
        step();
        step();
        chk_hs("pre reset full", 1'b1, 1'b0, 8'hD1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(if32.out_valid), 64'd0);
        chk("async rst in_ready",  64'(if32.in_ready),  64'd1);
        chk("async rst out_target", if64.out_target,    64'd0);
        chk("async rst out_tag",   64'(if64.out_tag),   64'd0);
        drive(1'b0, 3'd0, 32'h0, 64'h0, 8'h0);
        #3;
        rst_n = 1'b1;
        step();
        chk_hs("post reset", 1'b0, 1'b1, 8'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
